pipelined_adder: RTL and testbench

- Parametrised, pipelined add/subtract unit; the multi-bit, registered successor to the single-bit full-adder cell.
- Splits a WIDTH-bit operation into STAGES carry-chained slices, one slice per pipeline stage.
- Has a valid/ready handshake with full-pipeline stall on backpressure.
- Serves as the arithmetic building block for datapath units that need wide add/sub at a higher clock rate.

---
 rtl/adder_pkg.sv | 15 +
 rtl/adder_slice.sv | 25 ++
 rtl/pipelined_adder.sv | 121 ++++++++++++
 tb/tb_pipelined_adder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and configuration checks for the pipelined add/subtract unit.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // The width must split evenly into one slice per stage, with at least one bit per slice.
  function automatic bit legal_cfg(input int width, input int stages);
    if (stages < 1 || stages > width) return 1'b0;
    return (width % stages) == 0;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
module adder_slice
  import adder_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_in,
  input  logic [CHUNK-1:0] b_in,
  input  logic             carry_in,
  output logic [CHUNK-1:0] sum_out,
  output logic             carry_out
);

  logic w_carry [CHUNK+1];

  assign w_carry[0] = carry_in;

  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    assign sum_out[i]     = a_in[i] ^ b_in[i] ^ w_carry[i];
    assign w_carry[i + 1] = (a_in[i] & b_in[i]) | (w_carry[i] & (a_in[i] ^ b_in[i]));
  end

  assign carry_out = w_carry[CHUNK];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract: one CHUNK-bit carry-chained slice per stage,
// valid/ready handshake with a global stall when the output is held.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  input  op_e              op_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             ovf_out
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  if (!legal_cfg(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  // Per-stage state: operands travel with the partial sum so upper slices see them later.
  logic             r_valid [STAGES];
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic [WIDTH-1:0] r_sum   [STAGES];
  logic             r_carry [STAGES];

  logic             w_src_v     [STAGES];
  logic [WIDTH-1:0] w_src_a     [STAGES];
  logic [WIDTH-1:0] w_src_b     [STAGES];
  logic [WIDTH-1:0] w_src_sum   [STAGES];
  logic             w_src_c     [STAGES];
  logic [CHUNK-1:0] w_slice_sum [STAGES];
  logic             w_slice_cout[STAGES];
  logic [WIDTH-1:0] w_next_sum  [STAGES];

  logic             w_advance;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c_eff;
  logic             w_unused_ops;

  // Subtraction is a + ~b + ~borrow, so carry_out reads as "no borrow".
  assign w_b_eff = (op_in == OP_SUB) ? ~b_in : b_in;
  assign w_c_eff = (op_in == OP_SUB) ? ~carry_in : carry_in;

  assign w_advance = !r_valid[LAST] || ready_in;
  assign ready_out = w_advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_src_v[k]   = valid_in;
      assign w_src_a[k]   = a_in;
      assign w_src_b[k]   = w_b_eff;
      assign w_src_sum[k] = '0;
      assign w_src_c[k]   = w_c_eff;
    end else begin : g_body
      assign w_src_v[k]   = r_valid[k - 1];
      assign w_src_a[k]   = r_a[k - 1];
      assign w_src_b[k]   = r_b[k - 1];
      assign w_src_sum[k] = r_sum[k - 1];
      assign w_src_c[k]   = r_carry[k - 1];
    end

    adder_slice #(
      .CHUNK(CHUNK)
    ) u_slice (
      .a_in     (w_src_a[k][k*CHUNK +: CHUNK]),
      .b_in     (w_src_b[k][k*CHUNK +: CHUNK]),
      .carry_in (w_src_c[k]),
      .sum_out  (w_slice_sum[k]),
      .carry_out(w_slice_cout[k])
    );

    // Lower sum bits pass through untouched; this stage's chunk is spliced in.
    assign w_next_sum[k] = (w_src_sum[k] & ~(CHUNK_MASK << (k * CHUNK)))
                         | (WIDTH'(w_slice_sum[k]) << (k * CHUNK));
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      // NOTE: data registers are cleared too, so outputs are all-zero after reset rather than X.
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_sum[k]   <= '0;
        r_carry[k] <= 1'b0;
      end
    end else if (w_advance) begin
      // NOTE: non-blocking assignments let every stage sample its upstream's old value.
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= w_src_v[k];
        r_a[k]     <= w_src_a[k];
        r_b[k]     <= w_src_b[k];
        r_sum[k]   <= w_next_sum[k];
        r_carry[k] <= w_slice_cout[k];
      end
    end
  end

  assign valid_out = r_valid[LAST];
  assign sum_out   = r_sum[LAST];
  assign carry_out = r_carry[LAST];
  assign ovf_out   = (r_a[LAST][WIDTH-1] == r_b[LAST][WIDTH-1])
                  && (r_sum[LAST][WIDTH-1] != r_a[LAST][WIDTH-1]);

  // Only the sign bits of the final operand copies feed the overflow flag.
  assign w_unused_ops = ^{r_a[LAST], r_b[LAST]};

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder at WIDTH=8, STAGES=2 against a signed/unsigned integer model.
module tb_pipelined_adder;
  import adder_pkg::*;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         valid_in;
  logic         ready_out;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         carry_in;
  op_e          op_in;
  logic         valid_out;
  logic         ready_in;
  logic [W-1:0] sum_out;
  logic         carry_out;
  logic         ovf_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  pipelined_adder #(
    .WIDTH (W),
    .STAGES(S)
  ) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .a_in     (a_in),
    .b_in     (b_in),
    .carry_in (carry_in),
    .op_in    (op_in),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .sum_out  (sum_out),
    .carry_out(carry_out),
    .ovf_out  (ovf_out)
  );

  // Reference: {ovf, carry, sum} from integer arithmetic on the operand values.
  function automatic logic [W+1:0] model(logic [W-1:0] a, logic [W-1:0] b, logic cin, op_e op);
    int sa, sb, ua, ub, st, ut;
    logic ovf, cout;
    sa = $signed(a);
    sb = $signed(b);
    ua = int'(a);
    ub = int'(b);
    if (op == OP_ADD) begin
      st   = sa + sb + int'(cin);
      ut   = ua + ub + int'(cin);
      cout = (ut >= (1 << W));
    end else begin
      st   = sa - sb - int'(cin);
      ut   = ua - ub - int'(cin);
      cout = (ut >= 0);
    end
    ovf = (st > (1 << (W - 1)) - 1) || (st < -(1 << (W - 1)));
    return {ovf, cout, ut[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    a_in     = '0;
    b_in     = '0;
    carry_in = 1'b0;
    op_in    = OP_ADD;
  endtask

  task automatic drive(logic [W-1:0] a, logic [W-1:0] b, logic cin, op_e op);
    valid_in = 1'b1;
    a_in     = a;
    b_in     = b;
    carry_in = cin;
    op_in    = op;
  endtask

  task automatic test_reset();
    rst_in   = 1'b1;
    ready_in = 1'b1;
    idle();
    #1;
    checks++;
    if ({valid_out, ovf_out, carry_out, sum_out} !== '0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: got v=%b o=%b c=%b s=%h rdy=%b, want all 0 rdy=1",
               valid_out, ovf_out, carry_out, sum_out, ready_out);
    end
    tick();
    tick();
    rst_in = 1'b0;
    tick();
    checks++;
    if ({valid_out, ovf_out, carry_out, sum_out} !== '0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got v=%b o=%b c=%b s=%h rdy=%b, want all 0 rdy=1",
               valid_out, ovf_out, carry_out, sum_out, ready_out);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta   [5] = '{8'h7F, 8'hFF, 8'h0F, 8'h05, 8'h80};
    logic [W-1:0] tb   [5] = '{8'h01, 8'h01, 8'h00, 8'h07, 8'h01};
    logic         tc   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    op_e          top  [5] = '{OP_ADD, OP_ADD, OP_ADD, OP_SUB, OP_SUB};
    logic [W+1:0] texp [5] = '{{2'b10, 8'h80}, {2'b01, 8'h00}, {2'b00, 8'h10},
                               {2'b00, 8'hFE}, {2'b11, 8'h7F}};
    for (int i = 0; i < 5; i++) begin
      drive(ta[i], tb[i], tc[i], top[i]);
      tick();
      idle();
      checks++;
      if (valid_out !== 1'b0) begin
        errors++;
        $display("FAIL directed%0d_early: valid_out=%b, want 0", i, valid_out);
      end
      tick();
      checks++;
      if ({valid_out, ovf_out, carry_out, sum_out} !== {1'b1, texp[i]}) begin
        errors++;
        $display("FAIL directed%0d_result: got v=%b o=%b c=%b s=%h, want v=1 o=%b c=%b s=%h",
                 i, valid_out, ovf_out, carry_out, sum_out, texp[i][W+1], texp[i][W], texp[i][W-1:0]);
      end
      tick();
      checks++;
      if (valid_out !== 1'b0) begin
        errors++;
        $display("FAIL directed%0d_oneshot: valid_out=%b, want 0", i, valid_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ra [10];
    logic [W-1:0] rb [10];
    logic         rc [10];
    op_e          rop[10];
    logic [W+2:0] want;
    for (int i = 0; i < 10; i++) begin
      ra[i]  = W'($urandom);
      rb[i]  = W'($urandom);
      rc[i]  = 1'($urandom_range(0, 1));
      rop[i] = op_e'($urandom_range(0, 1));
    end
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 10) drive(ra[cyc], rb[cyc], rc[cyc], rop[cyc]);
      else idle();
      tick();
      if (cyc >= 1 && cyc <= 10)
        want = {1'b1, model(ra[cyc-1], rb[cyc-1], rc[cyc-1], rop[cyc-1])};
      else
        want = '0;
      checks++;
      if ({valid_out, ovf_out, carry_out, sum_out} !== want && (want[W+2] || valid_out !== 1'b0)) begin
        errors++;
        $display("FAIL stream_cyc%0d: got v=%b o=%b c=%b s=%h, want v=%b o=%b c=%b s=%h",
                 cyc, valid_out, ovf_out, carry_out, sum_out, want[W+2], want[W+1], want[W], want[W-1:0]);
      end
      checks++;
      if (ready_out !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready_cyc%0d: ready_out=%b, want 1", cyc, ready_out);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] pa [3];
    logic [W-1:0] pb [3];
    logic         pc [3];
    op_e          pop[3];
    logic [W+1:0] pe [3];
    for (int i = 0; i < 3; i++) begin
      pa[i]  = W'($urandom);
      pb[i]  = W'($urandom);
      pc[i]  = 1'($urandom_range(0, 1));
      pop[i] = op_e'($urandom_range(0, 1));
      pe[i]  = model(pa[i], pb[i], pc[i], pop[i]);
    end
    ready_in = 1'b1;
    drive(pa[0], pb[0], pc[0], pop[0]);
    tick();
    drive(pa[1], pb[1], pc[1], pop[1]);
    tick();
    ready_in = 1'b0;
    drive(pa[2], pb[2], pc[2], pop[2]);
    #1;
    for (int s = 0; s < 4; s++) begin
      checks++;
      if ({valid_out, ovf_out, carry_out, sum_out} !== {1'b1, pe[0]}) begin
        errors++;
        $display("FAIL stall%0d_hold: got v=%b o=%b c=%b s=%h, want v=1 o=%b c=%b s=%h",
                 s, valid_out, ovf_out, carry_out, sum_out, pe[0][W+1], pe[0][W], pe[0][W-1:0]);
      end
      checks++;
      if (ready_out !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d_ready: ready_out=%b, want 0", s, ready_out);
      end
      tick();
    end
    ready_in = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: ready_out=%b, want 1", ready_out);
    end
    tick();
    idle();
    for (int r = 1; r < 3; r++) begin
      checks++;
      if ({valid_out, ovf_out, carry_out, sum_out} !== {1'b1, pe[r]}) begin
        errors++;
        $display("FAIL drain%0d: got v=%b o=%b c=%b s=%h, want v=1 o=%b c=%b s=%h",
                 r, valid_out, ovf_out, carry_out, sum_out, pe[r][W+1], pe[r][W], pe[r][W-1:0]);
      end
      tick();
    end
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: valid_out=%b, want 0", valid_out);
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] na, nb;
    logic [W+1:0] ne;
    ready_in = 1'b1;
    drive(8'h12, 8'h34, 1'b0, OP_ADD);
    tick();
    drive(8'h56, 8'h78, 1'b1, OP_SUB);
    tick();
    idle();
    #3;
    rst_in = 1'b1;
    #1;
    checks++;
    if ({valid_out, ovf_out, carry_out, sum_out} !== '0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async: got v=%b o=%b c=%b s=%h rdy=%b, want all 0 rdy=1",
               valid_out, ovf_out, carry_out, sum_out, ready_out);
    end
    tick();
    #2;
    rst_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (valid_out !== 1'b0) begin
        errors++;
        $display("FAIL midreset_stale%0d: valid_out=%b, want 0", c, valid_out);
      end
    end
    na = W'($urandom);
    nb = W'($urandom);
    ne = model(na, nb, 1'b1, OP_ADD);
    drive(na, nb, 1'b1, OP_ADD);
    tick();
    idle();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_early: valid_out=%b, want 0", valid_out);
    end
    tick();
    checks++;
    if ({valid_out, ovf_out, carry_out, sum_out} !== {1'b1, ne}) begin
      errors++;
      $display("FAIL post_reset_result: got v=%b o=%b c=%b s=%h, want v=1 o=%b c=%b s=%h",
               valid_out, ovf_out, carry_out, sum_out, ne[W+1], ne[W], ne[W-1:0]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
